fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_pkg.sv | 21 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and width helpers for the FIFO write arbiter
// Contents:
//   state_e  - arbiter FSM state (idle / transferring a burst)
//   grant_w  - width of a requester index, at least 1 bit
//   cnt_w    - width of a counter that must hold the value max_val
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  function automatic int grant_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin priority selector
// Ports:
//   req_i    - request vector, one bit per requester
//   last_i   - index of the requester served last; it gets the lowest priority
//   onehot_o - one-hot winner (all zero when nothing requests)
//   idx_o    - binary index of the winner (0 when nothing requests)
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int GRANT_W = 1
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [GRANT_W-1:0] last_i,
  output logic [N_REQ-1:0]   onehot_o,
  output logic [GRANT_W-1:0] idx_o
);

  logic found;

  // Visit positions last+1, last+2, ... (mod N_REQ); the first requester seen wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && (j == ((int'(last_i) + k) % N_REQ)) && req_i[j]) begin
          found       = 1'b1;
          onehot_o[j] = 1'b1;
          idx_o       = GRANT_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the prefetch FIFO write port
// Ports:
//   clk, rst      - write-side clock, synchronous active-high reset
//   req_valid     - per-requester word valid
//   req_last      - per-requester last word of packet, qualified by req_valid
//   req_data      - packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     - per-requester accept
//   fifo_wr_en    - FIFO write enable
//   fifo_wr_data  - FIFO write data
//   fifo_wr_vld   - FIFO can take a write this cycle
//   grant_valid   - a grant is active
//   grant_id      - granted requester
//   burst_cnt     - words written during the current grant
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int N_REQ         = 2,
  parameter  int DATA_WIDTH    = 32,
  parameter  int MAX_BURST     = 16,
  parameter  int STALL_TIMEOUT = 8,
  localparam int GRANT_W       = grant_w(N_REQ),
  localparam int CNT_W         = cnt_w(MAX_BURST)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  input  logic                        fifo_wr_vld,
  output logic                        grant_valid,
  output logic [GRANT_W-1:0]          grant_id,
  output logic [CNT_W-1:0]            burst_cnt
);

  localparam int STALL_W = cnt_w(STALL_TIMEOUT);

  state_e               state_q;
  logic                 grant_valid_q;
  logic [GRANT_W-1:0]   grant_id_q;
  logic [GRANT_W-1:0]   rr_q;
  logic [CNT_W-1:0]     burst_cnt_q;
  logic [STALL_W-1:0]   stall_q;
  logic [STALL_W-1:0]   stall_d;

  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  xfer;
  logic                  wr_en;
  logic                  last_word;
  logic                  stall_expire;
  logic [N_REQ-1:0]      pick_onehot;
  logic [GRANT_W-1:0]    pick_idx;
  logic                  pick_any;

  fifo_wr_arbiter_rr_pick #(
    .N_REQ   (N_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr_pick (
    .req_i    (req_valid),
    .last_i   (rr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  assign pick_any = |pick_onehot;

  // Mux the granted requester's handshake and data onto the FIFO side.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == GRANT_W'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (xfer && (grant_id_q == GRANT_W'(i))) req_ready[i] = fifo_wr_vld;
    end
  end

  assign xfer         = (state_q == ST_XFER);
  assign wr_en        = xfer & g_valid & fifo_wr_vld;
  // Cap check uses the pre-increment count, so the cap word itself is the last write.
  assign last_word    = g_last | (burst_cnt_q == CNT_W'(MAX_BURST - 1));
  assign stall_d      = stall_q + STALL_W'(1);
  assign stall_expire = (stall_d == STALL_W'(STALL_TIMEOUT));

  assign fifo_wr_en   = wr_en;
  assign fifo_wr_data = g_data;
  assign grant_valid  = grant_valid_q;
  assign grant_id     = grant_id_q;
  assign burst_cnt    = burst_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      burst_cnt_q   <= '0;
      stall_q       <= '0;
      rr_q          <= GRANT_W'(N_REQ - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q       <= ST_XFER;
            grant_valid_q <= 1'b1;
            grant_id_q    <= pick_idx;
            burst_cnt_q   <= '0;
            stall_q       <= '0;
          end
        end
        ST_XFER: begin
          if (wr_en) begin
            burst_cnt_q <= burst_cnt_q + CNT_W'(1);
            stall_q     <= '0;
            if (last_word) begin
              state_q       <= ST_IDLE;
              grant_valid_q <= 1'b0;
              rr_q          <= grant_id_q;
            end
          end else if (!g_valid) begin
            if (stall_expire) begin
              state_q       <= ST_IDLE;
              grant_valid_q <= 1'b0;
              rr_q          <= grant_id_q;
            end else begin
              stall_q <= stall_d;
            end
          end else begin
            // FIFO full while the requester is valid: backpressure, keep the grant.
            stall_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int MB = 16;
  localparam int ST = 8;
  localparam int GW = 1;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_wr_vld;
  logic            grant_valid;
  logic [GW-1:0]   grant_id;
  logic [CW-1:0]   burst_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .STALL_TIMEOUT(ST)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_vld(fifo_wr_vld),
    .grant_valid(grant_valid), .grant_id(grant_id), .burst_cnt(burst_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Source side: each requester offers the head of its own word queue.
  logic [DW-1:0] src_data[N][$];
  bit            src_last[N][$];
  bit            gate[N];
  int            seq_out[N];
  int            seq_exp[N];

  // Reference model of the arbitration rules.
  bit m_busy;
  int m_gid, m_cnt, m_stall, m_rr;

  // Observations of the DUT.
  int obs_g[$], obs_w[$], obs_t[$], obs_lw[$];
  int obs_writes, last_wr_cyc, cyc;
  logic prev_gv;
  logic s_gv, s_wen;
  logic [GW-1:0] s_gid;
  logic [CW-1:0] s_bc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i, input int s);
    return {8'(i), 24'(s)};
  endfunction

  task automatic push(input int i, input int len, input bit with_last);
    for (int k = 0; k < len; k++) begin
      src_data[i].push_back(word(i, seq_out[i]));
      src_last[i].push_back(with_last && (k == len - 1));
      seq_out[i]++;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_cnt = 0; m_stall = 0; m_rr = N - 1;
  endtask

  task automatic clear_obs();
    obs_g.delete(); obs_w.delete(); obs_t.delete(); obs_lw.delete();
    obs_writes = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (gate[i] && src_data[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_last[i]  = src_last[i][0];
        req_data[i*DW +: DW] = src_data[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'($urandom_range(0, 1));
        req_data[i*DW +: DW] = $urandom;
      end
    end
  endtask

  // One clock: drive, check outputs at negedge against the model, advance model, retire accepted words.
  task automatic step();
    bit acc[N];
    int g;
    bit we;
    logic [N-1:0] exp_rdy;
    drive();
    @(negedge clk);
    g = m_gid;
    we = m_busy && req_valid[g] && fifo_wr_vld;
    exp_rdy = '0;
    if (m_busy && fifo_wr_vld) exp_rdy[g] = 1'b1;
    chk("grant_valid", grant_valid, m_busy);
    chk("grant_id", grant_id, m_gid);
    chk("burst_cnt", burst_cnt, m_cnt);
    chk("req_ready", req_ready, exp_rdy);
    chk("fifo_wr_en", fifo_wr_en, we);
    if (we) begin
      chk("fifo_wr_data", fifo_wr_data, word(g, seq_exp[g]));
      seq_exp[g]++;
    end
    s_gv = grant_valid; s_wen = fifo_wr_en; s_gid = grant_id; s_bc = burst_cnt;
    if (grant_valid === 1'b1 && prev_gv !== 1'b1) begin
      obs_g.push_back(int'(grant_id)); obs_w.push_back(0);
      obs_t.push_back(cyc); obs_lw.push_back(last_wr_cyc);
    end
    if (fifo_wr_en === 1'b1) begin
      obs_writes++;
      last_wr_cyc = cyc;
      if (obs_w.size() > 0) obs_w[obs_w.size()-1]++;
    end
    prev_gv = grant_valid;
    cyc++;
    for (int i = 0; i < N; i++) acc[i] = (req_valid[i] === 1'b1) && (req_ready[i] === 1'b1);
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        if (!m_busy && req_valid[(m_rr + k) % N]) begin
          m_gid = (m_rr + k) % N; m_busy = 1; m_cnt = 0; m_stall = 0;
        end
      end
    end else if (we) begin
      m_cnt++; m_stall = 0;
      if (req_last[g] || m_cnt == MB) begin m_busy = 0; m_rr = g; end
    end else if (!req_valid[g]) begin
      m_stall++;
      if (m_stall == ST) begin m_busy = 0; m_rr = g; end
    end else begin
      m_stall = 0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(src_data[i].pop_front());
        void'(src_last[i].pop_front());
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    bit done;
    done = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      step();
      done = (s_gv === 1'b0);
      for (int i = 0; i < N; i++) if (src_data[i].size() != 0) done = 0;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    cyc = 0; last_wr_cyc = 0; prev_gv = 1'b0;
    for (int i = 0; i < N; i++) begin gate[i] = 1; seq_out[i] = 0; seq_exp[i] = 0; end
    clear_obs();
    model_reset();
    rst = 1'b1;
    fifo_wr_vld = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_burst_cnt", burst_cnt, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fifo_wr_en", fifo_wr_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 5-word packet from requester 0
    clear_obs();
    push(0, 5, 1);
    step(); chk("s1_arb_gv", s_gv, 0);
    step(); chk("s1_gv", s_gv, 1); chk("s1_gid", s_gid, 0); chk("s1_first_wr", s_wen, 1);
    drain("s1_drain", 20);
    chk("s1_words", obs_w[0], 5);
    chk("s1_burst_cnt", s_bc, 5);

    // both requesters streaming: capped bursts alternate
    do_reset(); clear_obs();
    push(0, 40, 1); push(1, 40, 1);
    drain("s2_drain", 300);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s2_grant%0d", k), obs_g[k], k % 2);
      chk($sformatf("s2_words%0d", k), obs_w[k], MB);
    end
    chk("s2_bubble", obs_t[1] - obs_t[0], MB + 1);

    // FIFO full for 20 cycles after word 3
    do_reset(); clear_obs();
    push(0, 8, 1);
    for (int c = 0; c < 10 && obs_writes < 3; c++) step();
    fifo_wr_vld = 1'b0;
    repeat (20) step();
    chk("s3_held_gv", s_gv, 1);
    chk("s3_held_cnt", s_bc, 3);
    chk("s3_held_wen", s_wen, 0);
    fifo_wr_vld = 1'b1;
    drain("s3_drain", 40);
    chk("s3_writes", obs_writes, 8);
    chk("s3_grants", obs_g.size(), 1);

    // requester 0 goes quiet after 2 words; timeout hands over to requester 1
    do_reset(); clear_obs();
    push(0, 2, 0); push(1, 4, 1);
    drain("s4_drain", 60);
    chk("s4_grants", obs_g.size(), 2);
    chk("s4_g0", obs_g[0], 0);
    chk("s4_g1", obs_g[1], 1);
    chk("s4_w0", obs_w[0], 2);
    chk("s4_gap", obs_t[1] - obs_lw[1], ST + 2);

    // last flag on the cap word: one release only
    do_reset(); clear_obs();
    push(0, MB, 1); push(1, 3, 1);
    drain("s5_drain", 80);
    chk("s5_grants", obs_g.size(), 2);
    chk("s5_g0", obs_g[0], 0);
    chk("s5_g1", obs_g[1], 1);
    chk("s5_w0", obs_w[0], MB);
    chk("s5_w1", obs_w[1], 3);

    // reset during word 7
    do_reset(); clear_obs();
    push(0, 20, 1); push(1, 5, 1);
    for (int c = 0; c < 20 && obs_writes < 6; c++) step();
    do_reset();
    step();
    chk("s6_gv", s_gv, 0); chk("s6_wen", s_wen, 0); chk("s6_cnt", s_bc, 0);
    step();
    chk("s6_regrant_gv", s_gv, 1); chk("s6_regrant_id", s_gid, 0);
    drain("s6_drain", 200);

    // random traffic, gating and FIFO backpressure
    do_reset(); clear_obs();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src_data[i].size() < 4 && $urandom_range(0, 7) == 0)
          push(i, $urandom_range(1, 40), $urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) gate[i] = !gate[i];
      end
      fifo_wr_vld = ($urandom_range(0, 3) != 0);
      step();
    end
    for (int i = 0; i < N; i++) gate[i] = 1;
    fifo_wr_vld = 1'b1;
    drain("rand_drain", 2000);
    for (int i = 0; i < N; i++) chk($sformatf("rand_seq%0d", i), seq_exp[i], seq_out[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
